// File: rtl/imem_boot_ctrl_pkg.sv
// Shared types and constants for the instruction-memory boot/run sequencer.
package imem_boot_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HOLD,
    RUN,
    DONE
  } boot_state_t;

  localparam int XLEN           = 32;
  localparam int DEF_IMEM_DEPTH = 256;

  // addi x0, x0, 0 -- filler word for unused program slots
  localparam logic [XLEN-1:0] NOP = 32'h00000013;

endpackage

// File: rtl/imem_boot_ctrl.sv
// Boot/run sequencer: holds the core in reset, streams a program into imem,
// then releases the core for a bounded number of cycles and flags completion.
module imem_boot_ctrl
  import imem_boot_ctrl_pkg::*;
#(
  parameter int IMEM_DEPTH = DEF_IMEM_DEPTH,
  parameter int ADDR_W     = $clog2(IMEM_DEPTH),
  parameter int DATA_W     = XLEN,
  parameter int CNT_W      = 16,
  parameter int RST_HOLD   = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [ADDR_W:0]   load_len,
  input  logic [CNT_W-1:0]  run_cycles,
  input  logic              stop,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              core_resetn,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  cycle_count
);

  localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W + 1)'(IMEM_DEPTH);
  localparam int              HOLD_W    = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

  boot_state_t       state;
  boot_state_t       state_nxt;
  logic [ADDR_W:0]   len_q;
  logic [CNT_W-1:0]  rc_q;
  logic [ADDR_W:0]   wr_ptr;
  logic [HOLD_W-1:0] hold_cnt;
  logic              accept;
  logic              len_ok;
  logic              last_beat;
  logic              run_end;
  logic              idle_like;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  assign s_ready = (state == LOAD);

  always_comb begin
    state_nxt = state;
    idle_like = (state == IDLE) || (state == DONE);
    accept    = (state == LOAD) && s_valid;
    len_ok    = (load_len != '0) && (load_len <= DEPTH_L);
    last_beat = ((wr_ptr + 1'b1) == len_q);
    run_end   = (rc_q != '0) && (cycle_count == rc_q - 1'b1);
    case (state)
      IDLE, DONE: if (start) state_nxt = len_ok ? LOAD : IDLE;
      LOAD: begin
        if (stop)                        state_nxt = IDLE;
        else if (accept && last_beat)    state_nxt = HOLD;
      end
      HOLD: begin
        if (stop)                        state_nxt = IDLE;
        else if (hold_cnt == HOLD_LAST)  state_nxt = RUN;
      end
      RUN:  if (stop || run_end) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      len_q       <= '0;
      rc_q        <= '0;
      wr_ptr      <= '0;
      hold_cnt    <= '0;
      imem_we     <= 1'b0;
      imem_waddr  <= '0;
      imem_wdata  <= '0;
      core_resetn <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      cycle_count <= '0;
    end else begin
      state       <= state_nxt;
      core_resetn <= (state_nxt == RUN);
      busy        <= (state_nxt == LOAD) || (state_nxt == HOLD) || (state_nxt == RUN);
      done        <= (state_nxt == DONE);

      // write port: accepted beat lands in imem one cycle later
      imem_we <= accept;
      if (accept) begin
        imem_waddr <= wr_ptr[ADDR_W-1:0];
        imem_wdata <= s_data;
        wr_ptr     <= wr_ptr + 1'b1;
      end

      hold_cnt <= (state == HOLD) ? hold_cnt + 1'b1 : '0;

      if (state == RUN) cycle_count <= sat_inc(cycle_count);

      if (idle_like && start) begin
        err         <= !len_ok;
        cycle_count <= '0;
        if (len_ok) begin
          len_q  <= load_len;
          rc_q   <= run_cycles;
          wr_ptr <= '0;
        end
      end else if (stop && ((state == LOAD) || (state == HOLD))) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Self-checking bench for imem_boot_ctrl: directed and randomized load/run sessions
// compared against session-level expectations derived from the sequencing rules.
module tb_imem_boot_ctrl;
  import imem_boot_ctrl_pkg::*;

  localparam int RST_HOLD = 2;

  logic        clk;
  logic        resetn;
  logic        start, stop, s_valid;
  logic [8:0]  load_len;
  logic [15:0] run_cycles;
  logic [31:0] s_data;
  logic        s_ready, imem_we, core_resetn, busy, done, err;
  logic [7:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic [15:0] cycle_count;

  // narrow-counter instance used only for the saturation check
  logic        start_s, stop_s;
  logic [3:0]  run_cycles_s;
  logic        s2_ready, s2_we, s2_core, s2_busy, s2_done, s2_err;
  logic [7:0]  s2_waddr;
  logic [31:0] s2_wdata;
  logic [3:0]  s2_cnt;

  imem_boot_ctrl #(.RST_HOLD(RST_HOLD)) dut (
    .clk(clk), .resetn(resetn), .start(start), .load_len(load_len),
    .run_cycles(run_cycles), .stop(stop), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .core_resetn(core_resetn), .busy(busy),
    .done(done), .err(err), .cycle_count(cycle_count)
  );

  imem_boot_ctrl #(.CNT_W(4), .RST_HOLD(RST_HOLD)) dut_s (
    .clk(clk), .resetn(resetn), .start(start_s), .load_len(load_len),
    .run_cycles(run_cycles_s), .stop(stop_s), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s2_ready), .imem_we(s2_we), .imem_waddr(s2_waddr),
    .imem_wdata(s2_wdata), .core_resetn(s2_core), .busy(s2_busy),
    .done(s2_done), .err(s2_err), .cycle_count(s2_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] fixed_prog [8] = '{32'h01908093, 32'h04b10113, 32'h002080b3, 32'h40208133,
                                  32'h402080b3, 32'hffd08093, 32'h0020a023, 32'h0000a103};
  logic [31:0] prog [256];

  // observation side, filled on the falling edge
  logic [7:0]  obs_a [$];
  logic [31:0] obs_d [$];
  int cyc = 0;
  int run_hi, hs_cyc, rise_cyc;

  always @(negedge clk) begin
    cyc++;
    if (imem_we) begin
      obs_a.push_back(imem_waddr);
      obs_d.push_back(imem_wdata);
    end
    if (s_valid && s_ready) hs_cyc = cyc;
    if (core_resetn) begin
      run_hi++;
      if (rise_cyc < 0) rise_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_core"},  core_resetn, 0);
    chk({tag, "_we"},    imem_we, 0);
    chk({tag, "_waddr"}, imem_waddr, 0);
    chk({tag, "_wdata"}, imem_wdata, 0);
    chk({tag, "_ready"}, s_ready, 0);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_done"},  done, 0);
    chk({tag, "_err"},   err, 0);
    chk({tag, "_cnt"},   cycle_count, 0);
  endtask

  task automatic do_reset(input string tag);
    resetn = 1'b0;
    #1;
    check_reset_vals(tag);
    tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic clear_obs();
    obs_a.delete();
    obs_d.delete();
    run_hi   = 0;
    hs_cyc   = -1;
    rise_cyc = -1;
  endtask

  task automatic check_writes(input int nexp);
    chk("wr_count", obs_a.size(), nexp);
    for (int i = 0; i < nexp && i < obs_a.size(); i++) begin
      chk("wr_addr", obs_a[i], i);
      chk("wr_data", obs_d[i], prog[i]);
    end
  endtask

  task automatic illegal(input int len);
    clear_obs();
    start = 1'b1; load_len = 9'(len); run_cycles = 16'd5; s_valid = 1'b1;
    tick();
    start = 1'b0;
    chk("ill_err", err, 1);
    chk("ill_done", done, 0);
    chk("ill_busy", busy, 0);
    chk("ill_ready", s_ready, 0);
    chk("ill_cnt", cycle_count, 0);
    repeat (3) tick();
    s_valid = 1'b0;
    chk("ill_we_count", obs_a.size(), 0);
    chk("ill_err_held", err, 1);
    chk("ill_core_hi", run_hi, 0);
  endtask

  // One load+run session. abort_at>=0 aborts after that many accepted words;
  // abort_rst turns the abort (in LOAD or at RUN cycle stop_at) into an async reset.
  task automatic session(input int len, input int rc, input int gap, input int abort_at,
                         input bit abort_rst, input int stop_at, input bit poke,
                         input bit ss, input bit fixed);
    int acc, k, n;
    bit v, do_stop;
    clear_obs();
    for (int i = 0; i < len; i++) prog[i] = (fixed && i < 8) ? fixed_prog[i] : $urandom;
    start = 1'b1; stop = ss; load_len = 9'(len); run_cycles = 16'(rc);
    tick();
    start = 1'b0; stop = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_ready", s_ready, 1);
    chk("start_done", done, 0);
    chk("start_err", err, 0);
    chk("start_cnt", cycle_count, 0);
    acc = 0; k = 0;
    while (acc < len && acc != abort_at) begin
      case (gap)
        0:       v = 1'b1;
        1:       v = (k % 3 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      s_valid = v; s_data = prog[acc];
      tick();
      k++;
      if (v) acc++;
    end
    s_valid = 1'b0; s_data = NOP;

    if (abort_at >= 0) begin
      tick();
      if (abort_rst) begin
        do_reset("rst_load");
      end else begin
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("abort_err", err, 1);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_ready", s_ready, 0);
      end
      tick();
      chk("abort_core_hi", run_hi, 0);
      check_writes(abort_at);
      return;
    end

    chk("hold_core", core_resetn, 0);
    chk("hold_busy", busy, 1);
    chk("hold_ready", s_ready, 0);
    repeat (RST_HOLD) tick();
    chk("run_core", core_resetn, 1);
    do_stop = (stop_at > 0) && (rc == 0 || stop_at <= rc);
    n = do_stop ? stop_at : rc;
    for (int j = 1; j < n; j++) begin
      if (poke && j == 2) begin
        start = 1'b1; load_len = 9'd3;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    chk("pre_done", done, 0);
    chk("pre_cnt", cycle_count, n - 1);
    if (abort_rst) begin
      do_reset("rst_run");
      chk("rst_run_hi", run_hi, n - 1);
      check_writes(len);
      return;
    end
    stop = do_stop;
    tick();
    stop = 1'b0;
    chk("done", done, 1);
    chk("final_cnt", cycle_count, n);
    chk("done_core", core_resetn, 0);
    chk("done_busy", busy, 0);
    chk("done_err", err, 0);
    repeat (2) tick();
    chk("done_held", done, 1);
    chk("cnt_frozen", cycle_count, n);
    chk("run_cycles_hi", run_hi, n);
    chk("release_latency", rise_cyc - hs_cyc, 1 + RST_HOLD);
    check_writes(len);
  endtask

  task automatic sat_test();
    start_s = 1'b1; load_len = 9'd1; run_cycles_s = 4'd0;
    tick();
    start_s = 1'b0;
    s_valid = 1'b1; s_data = NOP;
    tick();
    s_valid = 1'b0;
    repeat (RST_HOLD) tick();
    chk("sat_core", s2_core, 1);
    repeat (14) tick();
    chk("sat_cnt14", s2_cnt, 14);
    repeat (3) tick();
    chk("sat_cnt_hold", s2_cnt, 15);
    stop_s = 1'b1;
    tick();
    stop_s = 1'b0;
    chk("sat_done", s2_done, 1);
    chk("sat_cnt_final", s2_cnt, 15);
  endtask

  initial begin
    int len, rc, sa;
    resetn = 1'b0; start = 1'b0; stop = 1'b0; s_valid = 1'b0; s_data = NOP;
    load_len = '0; run_cycles = '0; start_s = 1'b0; stop_s = 1'b0; run_cycles_s = '0;
    #3;
    check_reset_vals("por");
    tick();
    resetn = 1'b1;
    tick();

    session(8, 30, 0, -1, 0, -1, 0, 0, 1);
    session(8, 30, 1, -1, 0, -1, 0, 0, 1);
    illegal(0);
    illegal(257);
    session(8, 0, 0, -1, 0, 12, 0, 0, 0);
    session(8, 30, 0, 3, 0, -1, 0, 0, 0);
    session(8, 30, 0, 5, 1, -1, 0, 0, 0);
    session(8, 30, 0, -1, 1, 7, 0, 0, 0);
    session(8, 20, 2, -1, 0, -1, 0, 0, 0);
    session(6, 15, 0, -1, 0, -1, 1, 0, 0);
    session(5, 10, 0, -1, 0, 10, 0, 1, 0);
    session(256, 5, 0, -1, 0, -1, 0, 0, 0);
    sat_test();

    for (int r = 0; r < 10; r++) begin
      len = $urandom_range(1, 24);
      rc  = $urandom_range(0, 40);
      if (rc == 0) sa = $urandom_range(1, 30);
      else         sa = ($urandom_range(0, 1) == 1) ? $urandom_range(1, rc + 5) : -1;
      session(len, rc, $urandom_range(0, 2), -1, 0, sa, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
